channel_input_capture: RTL

//  Input-capture path of the advanced timer, mirroring the output-compare block.
//  Per channel: synchronise an external TIx pin, filter it, detect the programmed edge and prescale.
//  On each qualifying event the running counter arr_cnt is latched into a capture register,
//  and capture / over-capture flags are raised for the register file and interrupt logic.

---
 rtl/channel_input_capture.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/channel_input_capture.sv
// -----------------------------------------------------------------------------
// channel_input_capture
//
// Input-capture path of the advanced timer. Each channel does four things to
// its external TIx pin:
//   1. synchronises it with two flops,
//   2. filters out pulses shorter than a programmable length,
//   3. detects the programmed edge (rising, falling or both),
//   4. prescales the edge events.
// On each surviving event the running counter arr_cnt is latched into the
// channel's capture register, and the capture / over-capture flags are raised.
//
// Parameters
//   NCH            number of capture channels
//   CNT_W          width of arr_cnt and of each capture register
//
// Ports
//   pe_gen_clk     timer kernel clock
//   pe_gen_rstn    asynchronous, active-low reset
//   ti             raw capture pins, asynchronous to pe_gen_clk
//   arr_cnt        running timer counter
//   timing_enable  counter enable; low suppresses capture
//   r_cce          per-channel capture enable
//   r_ccp          edge polarity: 0 = rising, 1 = falling
//   r_ccnp         1 = capture on both edges (overrides r_ccp)
//   r_icf          filter length N per channel, bits [4i+3:4i]
//   r_icpsc        prescaler per channel, bits [2i+1:2i]:
//                  capture on every 1st / 2nd / 4th / 8th event
//   ccif_clr       one-cycle clear pulse for ccif
//   ccof_clr       one-cycle clear pulse for ccof
//   cc_cap         capture registers; channel i at [CNT_W*i +: CNT_W]
//   ccif           sticky capture flag
//   ccof           sticky over-capture flag
//   cap_pulse      one-cycle strobe per capture
//   tif            filtered pin level
// -----------------------------------------------------------------------------
module channel_input_capture #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
) (
    input  logic                 pe_gen_clk,
    input  logic                 pe_gen_rstn,
    input  logic [NCH-1:0]       ti,
    input  logic [CNT_W-1:0]     arr_cnt,
    input  logic                 timing_enable,
    input  logic [NCH-1:0]       r_cce,
    input  logic [NCH-1:0]       r_ccp,
    input  logic [NCH-1:0]       r_ccnp,
    input  logic [4*NCH-1:0]     r_icf,
    input  logic [2*NCH-1:0]     r_icpsc,
    input  logic [NCH-1:0]       ccif_clr,
    input  logic [NCH-1:0]       ccof_clr,
    output logic [CNT_W*NCH-1:0] cc_cap,
    output logic [NCH-1:0]       ccif,
    output logic [NCH-1:0]       ccof,
    output logic [NCH-1:0]       cap_pulse,
    output logic [NCH-1:0]       tif
);

    for (genvar g = 0; g < NCH; g++) begin : g_ch

        // Pin conditioning state.
        logic       s1;
        logic       s2;
        logic       tif_q;
        logic       tif_d;
        logic [3:0] flt_cnt;

        // Event and capture state.
        logic [2:0]       psc_cnt;
        logic [2:0]       psc_last;
        logic [CNT_W-1:0] cap_q;
        logic             ccif_q;
        logic             ccof_q;
        logic             pulse_q;

        logic [3:0] flt_n;
        logic [1:0] psc_sel;
        logic       rise;
        logic       fall;
        logic       edge_evt;
        logic       run;
        logic       capture;

        assign flt_n   = r_icf[4*g +: 4];
        assign psc_sel = r_icpsc[2*g +: 2];

        // Sync, filter and edge history keep running even while capture is
        // disabled, so tif always reflects the pin for slave-mode users.
        // The filter counter holds the number of consecutive clocks in which
        // s2 has disagreed with tif. It is compared with >= so that lowering
        // N while a count is in progress cannot leave it stranded above N.
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, regardless of statement order.
        always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
            if (!pe_gen_rstn) begin
                s1      <= 1'b0;
                s2      <= 1'b0;
                tif_q   <= 1'b0;
                tif_d   <= 1'b0;
                flt_cnt <= 4'd0;
            end else begin
                s1    <= ti[g];
                s2    <= s1;
                tif_d <= tif_q;
                if (s2 == tif_q) begin
                    flt_cnt <= 4'd0;
                end else if (flt_cnt >= flt_n) begin
                    tif_q   <= s2;
                    flt_cnt <= 4'd0;
                end else begin
                    flt_cnt <= flt_cnt + 4'd1;
                end
            end
        end

        assign rise     = tif_q & ~tif_d;
        assign fall     = ~tif_q & tif_d;
        assign edge_evt = r_ccnp[g] ? (rise | fall) : (r_ccp[g] ? fall : rise);
        assign run      = r_cce[g] & timing_enable;

        // Last prescaler count before a capture: (1 << psc_sel) - 1.
        // NOTE: every path of a combinational block assigns its outputs
        // (here via the default arm) so no latch is inferred.
        always_comb begin
            case (psc_sel)
                2'd0:    psc_last = 3'd0;
                2'd1:    psc_last = 3'd1;
                2'd2:    psc_last = 3'd3;
                default: psc_last = 3'd7;
            endcase
        end

        assign capture = run & edge_evt & (psc_cnt == psc_last);

        // Prescaler, capture register and flags. A set always wins over a
        // coinciding clear. Over-capture needs ccif to be genuinely pending,
        // i.e. not being cleared by software on the same clock.
        // NOTE: the capture register is an ordinary visible output register,
        // not a memory array, so it is reset along with the rest.
        always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
            if (!pe_gen_rstn) begin
                psc_cnt <= 3'd0;
                cap_q   <= '0;
                ccif_q  <= 1'b0;
                ccof_q  <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                if (!run) begin
                    psc_cnt <= 3'd0;
                end else if (edge_evt) begin
                    psc_cnt <= (psc_cnt == psc_last) ? 3'd0 : psc_cnt + 3'd1;
                end

                pulse_q <= capture;
                if (capture) begin
                    cap_q <= arr_cnt;
                end

                if (capture) begin
                    ccif_q <= 1'b1;
                end else if (ccif_clr[g]) begin
                    ccif_q <= 1'b0;
                end

                if (capture && ccif_q && !ccif_clr[g]) begin
                    ccof_q <= 1'b1;
                end else if (ccof_clr[g]) begin
                    ccof_q <= 1'b0;
                end
            end
        end

        assign cc_cap[CNT_W*g +: CNT_W] = cap_q;
        assign ccif[g]                  = ccif_q;
        assign ccof[g]                  = ccof_q;
        assign cap_pulse[g]             = pulse_q;
        assign tif[g]                   = tif_q;
    end

endmodule
